// File: rtl/port_uart_tx_if.sv
// Core-side write port and status/serial outputs of the PORT UART transmitter.
interface port_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DATA_IN;
  logic             WR_EN;
  logic             CLR_OVF;
  logic             TX;
  logic             FULL;
  logic             EMPTY;
  logic             BUSY;
  logic             OVF;

  // Driven by the CPU write decode, observed by the core.
  modport master (
    output DATA_IN, WR_EN, CLR_OVF,
    input  TX, FULL, EMPTY, BUSY, OVF
  );

  // The UART transmitter itself.
  modport slave (
    input  DATA_IN, WR_EN, CLR_OVF,
    output TX, FULL, EMPTY, BUSY, OVF
  );
endinterface

// File: rtl/port_uart_tx.sv
// PORT byte FIFO feeding an 8N1 UART transmitter; all outputs registered.
module port_uart_tx #(
  parameter int WIDTH      = 8,
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_SIZE   = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  port_uart_tx_if.slave io
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]    BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [PTR_SIZE:0]   OCC_FULL  = (PTR_SIZE + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [PTR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]    occ_q, occ_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 ovf_q, ovf_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];

  logic                 wr_acc;
  logic                 pop;
  logic                 baud_tc;

  // Next-state logic for the FIFO bookkeeping and the transmit FSM.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    baud_tc = (baud_q == BAUD_LAST);
    // FULL is the pre-edge occupancy, so a pop on the same edge cannot rescue a write.
    wr_acc  = io.WR_EN & ~full_q;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_tc ? '0 : baud_q + CNT_W'(1);
        if (baud_tc) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_tc ? '0 : baud_q + CNT_W'(1);
        if (baud_tc) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_tc ? '0 : baud_q + CNT_W'(1);
        if (baud_tc) begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_SIZE'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_SIZE'(pop);
    occ_d    = occ_q + (PTR_SIZE + 1)'(wr_acc) - (PTR_SIZE + 1)'(pop);
    full_d   = (occ_d == OCC_FULL);
    empty_d  = (occ_d == '0);
    // A dropped write beats a simultaneous clear.
    ovf_d    = (io.WR_EN & full_q) ? 1'b1 : (io.CLR_OVF ? 1'b0 : ovf_q);

    // Line level follows the state being entered so TX comes straight off a flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= io.DATA_IN;
  end

  assign io.TX    = tx_q;
  assign io.FULL  = full_q;
  assign io.EMPTY = empty_q;
  assign io.BUSY  = busy_q;
  assign io.OVF   = ovf_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Randomized bench for port_uart_tx against a queue-based frame model.
module tb_port_uart_tx;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = (W + 2) * D;

  logic CLK;
  logic RST_N;

  port_uart_tx_if #(.WIDTH(W)) bus ();

  port_uart_tx #(
    .WIDTH(W), .CLK_DIV(D), .FIFO_DEPTH(DEPTH), .PTR_SIZE(2)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .io(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: byte queue, frame-in-progress flag and position in the frame.
  logic [W-1:0] mq[$];
  logic         m_active;
  int           m_t;
  logic [W-1:0] m_cur;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_cur    = '0;
    m_ovf    = 1'b0;
  endtask

  // Line level implied by position in the current frame: start, 8 data LSB first, stop.
  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / D;
    if (idx == 0) return 1'b0;
    if (idx <= W) return m_cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_step(input logic wr, input logic [W-1:0] d, input logic clr);
    int  pre;
    logic acc;
    logic do_pop;
    if (!RST_N) begin
      model_reset();
      return;
    end
    pre    = mq.size();
    acc    = wr && (pre < DEPTH);
    do_pop = 1'b0;
    if (!m_active) begin
      if (pre > 0) begin
        do_pop = 1'b1;
        m_active = 1'b1;
        m_t = 0;
      end
    end else if (m_t == FRAME - 1) begin
      if (pre > 0) begin
        do_pop = 1'b1;
        m_t = 0;
      end else begin
        m_active = 1'b0;
        m_t = 0;
      end
    end else begin
      m_t++;
    end
    if (do_pop) m_cur = mq.pop_front();
    if (acc) mq.push_back(d);
    if (wr && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outs();
    chk("tx",    bus.TX,    exp_tx());
    chk("busy",  bus.BUSY,  m_active);
    chk("empty", bus.EMPTY, mq.size() == 0);
    chk("full",  bus.FULL,  mq.size() == DEPTH);
    chk("ovf",   bus.OVF,   m_ovf);
  endtask

  task automatic cyc(input logic wr, input logic [W-1:0] d, input logic clr);
    bus.WR_EN   = wr;
    bus.DATA_IN = d;
    bus.CLR_OVF = clr;
    @(posedge CLK);
    model_step(wr, d, clr);
    #1;
    check_outs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || mq.size() != 0) && n < 2000) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_bound", n < 2000, 1);
  endtask

  initial begin
    int n;
    int busy_cnt;
    logic [9:0] pat;

    RST_N = 1'b1;
    bus.WR_EN = 1'b0;
    bus.DATA_IN = '0;
    bus.CLR_OVF = 1'b0;
    model_reset();

    // Reset values, applied asynchronously before any clock edge.
    #2 RST_N = 1'b0;
    #1;
    check_outs();
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));

    // Single byte 0xA5.
    pat = {1'b1, 8'hA5, 1'b0};
    cyc(1'b1, 8'hA5, 1'b0);
    chk("a5_tx_edge0", bus.TX, 1);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < D; c++) begin
        cyc(1'b0, '0, 1'b0);
        chk("a5_bit", bus.TX, pat[i]);
        chk("a5_empty", bus.EMPTY, 1);
        if (bus.BUSY) busy_cnt++;
      end
    end
    chk("a5_busy_cnt", busy_cnt, 40);
    cyc(1'b0, '0, 1'b0);
    chk("a5_busy_fall", bus.BUSY, 0);

    // Burst of six writes: five frames, last byte dropped.
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0);
      if (i == 4) chk("burst_full", bus.FULL, 1);
      if (i == 5) chk("burst_ovf", bus.OVF, 1);
    end
    n = 0;
    while (bus.BUSY && n < 400) begin
      cyc(1'b0, '0, 1'b0);
      if (bus.BUSY) n++;
    end
    chk("burst_busy_len", 5 + n, 200);

    // Full FIFO written on the edge that ends a STOP bit.
    drain();
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0);
    n = 0;
    while (!(m_active && m_t == FRAME - 1 && mq.size() == DEPTH) && n < 100) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    chk("popedge_bound", n < 100, 1);
    cyc(1'b1, 8'h77, 1'b0);
    chk("popedge_ovf", bus.OVF, 1);
    chk("popedge_full", bus.FULL, 0);
    chk("popedge_empty", bus.EMPTY, 0);

    // Overflow clear, then clear colliding with a drop.
    cyc(1'b0, '0, 1'b1);
    chk("clr_ovf", bus.OVF, 0);
    cyc(1'b1, 8'($urandom), 1'b0);
    chk("refill_full", bus.FULL, 1);
    cyc(1'b1, 8'($urandom), 1'b1);
    chk("clr_vs_drop", bus.OVF, 1);

    // Randomized traffic with occasional bursts.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        for (int b = 0; b < 6; b++) cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 29) == 0));
      end else begin
        cyc(1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom_range(0, 29) == 0));
      end
    end

    // Reset in the middle of data bit 3 with two bytes queued.
    drain();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0);
    n = 0;
    while (!(m_active && m_t == 4 * D + 1) && n < 100) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    chk("midframe_bound", n < 100, 1);
    chk("midframe_queued", mq.size(), 2);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_tx", bus.TX, 1);
    chk("rst_async_busy", bus.BUSY, 0);
    chk("rst_async_empty", bus.EMPTY, 1);
    model_reset();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, '0, 1'b0);
      chk("post_rst_tx", bus.TX, 1);
    end
    chk("post_rst_empty", bus.EMPTY, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
